mult_div_unit: RTL and testbench

- Parametrised multiply/divide unit holding the HI/LO pair; sits in the E stage beside the ALU.
- Driven by the decoder's start/op signals. Provides Busy so the hazard logic can stall HI/LO-dependent instructions.
- Adds over the previous generation: configurable width and latencies, multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU), and a cancel input for pipeline flush.

---
 rtl/mult_div_unit.sv | 149 ++++++++++++++
 tb/tb_mult_div_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multiply/divide unit owning the HI/LO pair; long ops run for a fixed latency
// and commit a pending result held since the accept edge.
module mult_div_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    // state | meaning
    // IDLE  | accepting ops; MTHI/MTLO write immediately
    // RUN   | long op counting down, pending result awaiting commit
    typedef enum logic {IDLE, RUN} state_t;

    localparam int LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);
    localparam int W2      = 2 * WIDTH;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic               pend_wr_q, pend_wr_d;

    logic               signed_op;
    logic [W2-1:0]      a_ext, b_ext, prod, acc;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b, div_b, quo, rem, quo_f, rem_f;

    assign signed_op = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);

    // Sign- or zero-extend to 2W so a single multiplier serves both flavours.
    assign a_ext = {{WIDTH{signed_op & rs_data[WIDTH-1]}}, rs_data};
    assign b_ext = {{WIDTH{signed_op & rt_data[WIDTH-1]}}, rt_data};
    assign prod  = a_ext * b_ext;
    assign acc   = {hi_q, lo_q};

    // Divide on magnitudes, then restore signs; MIN/-1 falls out as 0x80..0, rem 0.
    assign neg_a = signed_op & rs_data[WIDTH-1];
    assign neg_b = signed_op & rt_data[WIDTH-1];
    assign mag_a = neg_a ? -rs_data : rs_data;
    assign mag_b = neg_b ? -rt_data : rt_data;
    assign div_b = (rt_data == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    assign quo   = mag_a / div_b;
    assign rem   = mag_a % div_b;
    assign quo_f = (neg_a ^ neg_b) ? -quo : quo;
    assign rem_f = neg_a ? -rem : rem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            if (op == OP_MULT || op == OP_MULTU)
                                {pend_hi_d, pend_lo_d} = prod;
                            else if (op == OP_MADD || op == OP_MADDU)
                                {pend_hi_d, pend_lo_d} = acc + prod;
                            else
                                {pend_hi_d, pend_lo_d} = acc - prod;
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_LAT);
                            state_d   = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d = rem_f;
                            pend_lo_d = quo_f;
                            pend_wr_d = (rt_data != '0);
                            cnt_d     = CNT_W'(DIV_LAT);
                            state_d   = RUN;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cancel) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    pend_wr_d = 1'b0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    pend_wr_d = 1'b0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus random ops against a
// transaction-level HI/LO model.
module tb_mult_div_unit;
    localparam int WIDTH    = 32;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset, start, cancel;
    logic [3:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        busy;
    logic [31:0] hi, lo;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_div_unit #(.WIDTH(WIDTH), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .cancel(cancel),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Architectural result of one op applied to (h,l), plus its busy length.
    function automatic void ref_model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] h, input logic [31:0] l,
                                      output logic [31:0] nh, output logic [31:0] nl, output int lat);
        longint      ps;
        logic [63:0] pu, accv;
        int          sa, sb;
        ps   = longint'(int'(a)) * longint'(int'(b));
        pu   = 64'(a) * 64'(b);
        accv = {h, l};
        sa   = int'(a);
        sb   = int'(b);
        nh   = h;
        nl   = l;
        lat  = 0;
        case (o)
            4'd1:  begin {nh, nl} = ps;          lat = MULT_LAT; end
            4'd2:  begin {nh, nl} = pu;          lat = MULT_LAT; end
            4'd7:  begin {nh, nl} = accv + ps;   lat = MULT_LAT; end
            4'd8:  begin {nh, nl} = accv + pu;   lat = MULT_LAT; end
            4'd9:  begin {nh, nl} = accv - ps;   lat = MULT_LAT; end
            4'd10: begin {nh, nl} = accv - pu;   lat = MULT_LAT; end
            4'd3: begin
                lat = DIV_LAT;
                if (b != 0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        nl = 32'h8000_0000;
                        nh = 32'h0;
                    end else begin
                        nl = sa / sb;
                        nh = sa % sb;
                    end
                end
            end
            4'd4: begin
                lat = DIV_LAT;
                if (b != 0) begin
                    nl = a / b;
                    nh = a % b;
                end
            end
            4'd5: nh = a;
            4'd6: nl = a;
            default: ;
        endcase
    endfunction

    // cancel_at < 0: cancel alongside start; k > 0: cancel on busy cycle k.
    // junk_at: busy cycle on which a further start/junk_op is presented.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int cancel_at, input int junk_at, input logic [3:0] junk_op);
        logic [31:0] nh, nl;
        int          lat;
        bit          cancelled;
        ref_model(o, a, b, exp_hi, exp_lo, nh, nl, lat);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b; cancel = (cancel_at < 0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        if (cancel_at < 0 || lat == 0) begin
            if (cancel_at >= 0) begin
                exp_hi = nh;
                exp_lo = nl;
            end
            check_val("busy_idle", {31'b0, busy}, 32'd0);
            check_val("hi_idle", hi, exp_hi);
            check_val("lo_idle", lo, exp_lo);
            return;
        end
        cancelled = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            check_val("busy_run", {31'b0, busy}, 32'd1);
            check_val("hi_hold", hi, exp_hi);
            check_val("lo_hold", lo, exp_lo);
            if (k == cancel_at) cancel = 1'b1;
            if (k == junk_at) begin
                start = 1'b1; op = junk_op; rs_data = $urandom; rt_data = $urandom;
            end
            @(negedge clk);
            start = 1'b0; cancel = 1'b0;
            if (k == cancel_at) begin
                cancelled = 1'b1;
                break;
            end
        end
        check_val("busy_done", {31'b0, busy}, 32'd0);
        if (!cancelled) begin
            exp_hi = nh;
            exp_lo = nl;
        end
        check_val("hi_done", hi, exp_hi);
        check_val("lo_done", lo, exp_lo);
    endtask

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra, rb;
        int          rc, rj;

        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; rs_data = '0; rt_data = '0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", {31'b0, busy}, 32'd0);
        check_val("rst_hi", hi, 32'd0);
        check_val("rst_lo", lo, 32'd0);
        reset = 1'b0;

        // Reset on the 3rd busy cycle of a MULT wipes HI/LO and the pending result.
        run_op(4'd5, 32'h55, 32'h0, 0, 0, 4'd0);
        run_op(4'd6, 32'h66, 32'h0, 0, 0, 4'd0);
        @(negedge clk);
        start = 1'b1; op = 4'd1; rs_data = 32'd7; rt_data = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("midrst_busy", {31'b0, busy}, 32'd0);
        check_val("midrst_hi", hi, 32'd0);
        check_val("midrst_lo", lo, 32'd0);
        repeat (8) @(negedge clk);
        check_val("midrst_nocommit_hi", hi, 32'd0);
        check_val("midrst_nocommit_lo", lo, 32'd0);
        exp_hi = '0; exp_lo = '0;

        run_op(4'd1, 32'hFFFF_FFFD, 32'd5, 0, 0, 4'd0);
        run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 0, 0, 4'd0);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, 4'd0);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 4'd0);
        run_op(4'd5, 32'h11, 32'h0, 0, 0, 4'd0);
        run_op(4'd6, 32'h22, 32'h0, 0, 0, 4'd0);
        run_op(4'd4, 32'h1234, 32'h0, 0, 0, 4'd0);
        run_op(4'd6, 32'h10, 32'h0, 0, 0, 4'd0);
        run_op(4'd5, 32'h0, 32'h0, 0, 0, 4'd0);
        run_op(4'd7, 32'd3, 32'd4, 0, 0, 4'd0);
        run_op(4'd10, 32'h1D, 32'd1, 0, 0, 4'd0);

        // MTHI presented on busy cycle 2 must be ignored.
        run_op(4'd1, 32'h0001_0000, 32'h0003_0000, 0, 2, 4'd5);
        run_op(4'd1, 32'd6, 32'd7, -1, 0, 4'd0);
        run_op(4'd1, 32'd11, 32'd13, MULT_LAT, 0, 4'd0);
        for (int c = 11; c <= 15; c++) run_op(4'(c), $urandom, $urandom, 0, 0, 4'd0);
        run_op(4'd0, $urandom, $urandom, 0, 0, 4'd0);

        for (int i = 0; i < 80; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'($urandom_range(0, 3));
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            rc = 0;
            case ($urandom_range(0, 9))
                0: rc = -1;
                1, 2: rc = $urandom_range(1, DIV_LAT);
                default: ;
            endcase
            rj = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DIV_LAT) : 0;
            run_op(ro, ra, rb, rc, rj, 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
